// File: rtl/move_executor_if.sv
// Bundle of the move request, validator handshake and board RAM signals around move_executor.
// The slave modport is the executor's view; master is the surrounding environment.
interface move_executor_if;
  logic       move_req;
  logic       player;
  logic [2:0] origin_x;
  logic [2:0] origin_y;
  logic [2:0] destination_x;
  logic [2:0] destination_y;
  logic       start_validation;
  logic [3:0] piece_to_move;
  logic [5:0] address_validator;
  logic [3:0] piece_read;
  logic       move_valid;
  logic       validate_complete;
  logic [5:0] mem_address;
  logic [3:0] mem_data_in;
  logic       mem_write;
  logic [3:0] mem_data_out;
  logic       busy;
  logic       move_done;
  logic [1:0] result_code;
  logic [3:0] captured_piece;
  logic       king_captured;

  modport slave (
    input  move_req, player, origin_x, origin_y, destination_x, destination_y,
    input  address_validator, move_valid, validate_complete, mem_data_in,
    output start_validation, piece_to_move, piece_read, mem_address, mem_write,
    output mem_data_out, busy, move_done, result_code, captured_piece, king_captured
  );

  modport master (
    output move_req, player, origin_x, origin_y, destination_x, destination_y,
    output address_validator, move_valid, validate_complete, mem_data_in,
    input  start_validation, piece_to_move, piece_read, mem_address, mem_write,
    input  mem_data_out, busy, move_done, result_code, captured_piece, king_captured
  );
endinterface

// File: rtl/move_executor.sv
// Runs one chess move: reads origin/destination, screens it, asks the validator,
// then writes destination and clears origin, or rejects without touching the board.
module move_executor #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  move_executor_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_RD_ORG, S_RD_DST, S_CHK, S_START, S_ARM, S_WAIT_V, S_WR_DST, S_WR_ORG, S_DONE
  } state_t;

  state_t     state_q;
  logic       player_q;
  logic [5:0] org_addr_q;
  logic [5:0] dst_addr_q;
  logic [3:0] piece_q;
  logic [3:0] dst_piece_q;
  logic [7:0] cnt_q;
  logic       start_q;
  logic       write_q;
  logic [3:0] wdata_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] code_q;
  logic [3:0] cap_q;
  logic       king_q;
  logic [5:0] mem_address_d;

  // Codes 7..12 are black; anything nonzero below 7 is white.
  function automatic logic is_black(input logic [3:0] p);
    return p >= 4'd7;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      player_q    <= 1'b0;
      org_addr_q  <= '0;
      dst_addr_q  <= '0;
      piece_q     <= '0;
      dst_piece_q <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      code_q      <= '0;
      cap_q       <= '0;
      king_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      king_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.move_req) begin
            state_q    <= S_RD_ORG;
            busy_q     <= 1'b1;
            player_q   <= bus.player;
            org_addr_q <= {bus.origin_x, bus.origin_y};
            dst_addr_q <= {bus.destination_x, bus.destination_y};
            code_q     <= '0;
            cap_q      <= '0;
          end
        end
        S_RD_ORG: state_q <= S_RD_DST;
        S_RD_DST: begin
          piece_q <= bus.mem_data_in;
          state_q <= S_CHK;
        end
        S_CHK: begin
          dst_piece_q <= bus.mem_data_in;
          if (piece_q == 4'd0) begin
            code_q  <= 2'd1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (is_black(piece_q) != player_q) begin
            code_q  <= 2'd2;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if ((org_addr_q == dst_addr_q) ||
                       ((bus.mem_data_in != 4'd0) && (is_black(bus.mem_data_in) == player_q))) begin
            code_q  <= 2'd3;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: state_q <= S_ARM;
        // A complete level seen here may belong to the previous move, so it is not sampled.
        S_ARM: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_V;
        end
        S_WAIT_V: begin
          if (bus.validate_complete) begin
            if (bus.move_valid) begin
              write_q <= 1'b1;
              wdata_q <= piece_q;
              state_q <= S_WR_DST;
            end else begin
              code_q  <= 2'd3;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            code_q  <= 2'd3;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WR_DST: begin
          write_q <= 1'b1;
          wdata_q <= '0;
          state_q <= S_WR_ORG;
        end
        S_WR_ORG: begin
          done_q  <= 1'b1;
          code_q  <= 2'd0;
          cap_q   <= dst_piece_q;
          king_q  <= (dst_piece_q == 4'd6) || (dst_piece_q == 4'd12);
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The validator owns the read port for the whole wait.
  always_comb begin
    mem_address_d = '0;
    case (state_q)
      S_RD_ORG, S_WR_ORG: mem_address_d = org_addr_q;
      S_RD_DST, S_WR_DST: mem_address_d = dst_addr_q;
      S_WAIT_V:           mem_address_d = bus.address_validator;
      default:            mem_address_d = '0;
    endcase
  end

  assign bus.mem_address      = mem_address_d;
  assign bus.piece_read       = bus.mem_data_in;
  assign bus.start_validation = start_q;
  assign bus.piece_to_move    = piece_q;
  assign bus.mem_write        = write_q;
  assign bus.mem_data_out     = wdata_q;
  assign bus.busy             = busy_q;
  assign bus.move_done        = done_q;
  assign bus.result_code      = code_q;
  assign bus.captured_piece   = cap_q;
  assign bus.king_captured    = king_q;
endmodule

// File: tb/tb_move_executor.sv
// Drives move_executor with directed and random moves against a behavioural board model,
// a synchronous board RAM and a delay-programmable validator.
module tb_move_executor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_executor_if bus();
  move_executor #(.TIMEOUT_CYCLES(255)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Board RAM with a side load port for setting up positions.
  logic [3:0] ram [64];
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bus.mem_write) ram[bus.mem_address] <= bus.mem_data_out;
    bus.mem_data_in <= ram[bus.mem_address];
  end

  // Validator: completes v_delay cycles after seeing start; negative delay never completes.
  int   v_delay;
  bit   v_verdict;
  int   v_cnt;
  bit   v_run;
  logic v_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_done <= 1'b0; v_run <= 1'b0; v_cnt <= 0;
    end else if (bus.start_validation) begin
      v_done <= 1'b0; v_run <= (v_delay >= 0); v_cnt <= v_delay;
    end else if (v_run) begin
      if (v_cnt == 0) begin v_done <= 1'b1; v_run <= 1'b0; end
      else v_cnt <= v_cnt - 1;
    end
  end
  assign bus.validate_complete = v_done;
  assign bus.move_valid        = v_verdict;

  int board [64];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_cell(input int a, input int v);
    ld_en = 1'b1; ld_addr = 6'(a); ld_data = 4'(v);
    tick();
    ld_en = 1'b0;
    board[a] = v;
  endtask

  task automatic check_board(input string tag);
    int diffs = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== 4'(board[i])) diffs++;
    check(tag, 16'(diffs), 16'd0);
  endtask

  task automatic issue(input bit pl, input int ox, input int oy, input int dx, input int dy);
    bus.player = pl;
    bus.origin_x = 3'(ox); bus.origin_y = 3'(oy);
    bus.destination_x = 3'(dx); bus.destination_y = 3'(dy);
    bus.address_validator = 6'($urandom_range(0, 63));
    bus.move_req = 1'b1;
    tick();
    bus.move_req = 1'b0;
  endtask

  // Reference: the move rules applied to the board model, plus expected cycle of move_done.
  task automatic run_move(input string name, input bit pl, input int ox, input int oy,
                          input int dx, input int dy, input int vd, input bit vv, input bit extra);
    int o, d, org, dst, code, cap, king, exp_st, exp_done_t;
    int t, done_t, starts, start_t, writes, busy_low, addr_bad, idle_busy;
    logic [1:0] got_code;
    logic [3:0] got_cap, got_ptm;
    logic got_king;
    o = ox * 8 + oy; d = dx * 8 + dy;
    org = board[o]; dst = board[d];
    exp_st = 0; cap = 0; king = 0;
    if (org == 0) code = 1;
    else if ((org >= 7) != pl) code = 2;
    else if (o == d) code = 3;
    else if (dst != 0 && ((dst >= 7) == pl)) code = 3;
    else begin
      exp_st = 1;
      code = (vd < 0 || !vv) ? 3 : 0;
    end
    if (exp_st == 0) exp_done_t = 4;
    else if (vd < 0) exp_done_t = 6 + 255;
    else if (code == 0) exp_done_t = 9 + vd;
    else exp_done_t = 7 + vd;
    if (code == 0) begin
      cap = dst; king = (dst == 6 || dst == 12) ? 1 : 0;
      board[d] = org; board[o] = 0;
    end
    v_delay = vd; v_verdict = vv;
    issue(pl, ox, oy, dx, dy);
    t = 1; done_t = -1; starts = 0; start_t = -1; writes = 0; busy_low = 0; addr_bad = 0;
    got_code = '0; got_cap = '0; got_ptm = '0; got_king = 1'b0;
    while (t < 400) begin
      if (bus.start_validation) begin starts++; start_t = t; end
      if (bus.mem_write) writes++;
      if (!bus.busy) busy_low++;
      if (t == 6 && exp_st == 1 && bus.mem_address !== bus.address_validator) addr_bad++;
      if (bus.move_done) begin
        done_t = t; got_code = bus.result_code; got_cap = bus.captured_piece;
        got_king = bus.king_captured; got_ptm = bus.piece_to_move;
        break;
      end
      bus.move_req = extra && (t == 20);
      tick();
      t++;
    end
    bus.move_req = 1'b0;
    check({name, ".done_t"}, 16'(done_t), 16'(exp_done_t));
    check({name, ".code"}, 16'(got_code), 16'(code));
    check({name, ".captured"}, 16'(got_cap), 16'(cap));
    check({name, ".king"}, 16'(got_king), 16'(king));
    check({name, ".piece_to_move"}, 16'(got_ptm), 16'(org));
    check({name, ".starts"}, 16'(starts), 16'(exp_st));
    check({name, ".start_t"}, 16'(start_t), exp_st == 1 ? 16'd4 : 16'hFFFF);
    check({name, ".writes"}, 16'(writes), code == 0 ? 16'd2 : 16'd0);
    check({name, ".busy_low"}, 16'(busy_low), 16'd0);
    check({name, ".wait_addr"}, 16'(addr_bad), 16'd0);
    tick();
    check({name, ".done_pulse"}, 16'(bus.move_done), 16'd0);
    check({name, ".idle"}, 16'(bus.busy), 16'd0);
    check({name, ".code_hold"}, 16'(bus.result_code), 16'(code));
    check({name, ".cap_hold"}, 16'(bus.captured_piece), 16'(cap));
    if (extra) begin
      idle_busy = 0;
      for (int i = 0; i < 12; i++) begin
        if (bus.busy || bus.start_validation) idle_busy++;
        tick();
      end
      check({name, ".dropped_req"}, 16'(idle_busy), 16'd0);
    end
    check_board({name, ".board"});
    $display("[TB] %s pl=%0d (%0d,%0d)->(%0d,%0d) org=%0d dst=%0d vd=%0d vv=%0d code=%0d done_t=%0d",
             name, pl, ox, oy, dx, dy, org, dst, vd, vv, got_code, done_t);
  endtask

  initial begin
    int pl, ox, oy, dx, dy, r, pc;
    bus.move_req = 1'b0; bus.player = 1'b0;
    bus.origin_x = '0; bus.origin_y = '0; bus.destination_x = '0; bus.destination_y = '0;
    bus.address_validator = '0;
    v_delay = 0; v_verdict = 1'b1;
    for (int i = 0; i < 64; i++) load_cell(i, 0);
    check("rst.busy", 16'(bus.busy), 16'd0);
    check("rst.move_done", 16'(bus.move_done), 16'd0);
    check("rst.start", 16'(bus.start_validation), 16'd0);
    check("rst.mem_write", 16'(bus.mem_write), 16'd0);
    check("rst.result_code", 16'(bus.result_code), 16'd0);
    check("rst.captured", 16'(bus.captured_piece), 16'd0);
    check("rst.piece_to_move", 16'(bus.piece_to_move), 16'd0);
    check("rst.mem_address", 16'(bus.mem_address), 16'd0);
    rst_n = 1'b1;
    tick();

    load_cell(4 * 8 + 1, 1); load_cell(4 * 8 + 3, 0);
    run_move("pawn_push", 0, 4, 1, 4, 3, 1, 1, 0);
    load_cell(0 * 8 + 4, 0);
    run_move("origin_empty", 0, 0, 4, 0, 5, 0, 1, 0);
    load_cell(1 * 8 + 1, 9);
    run_move("wrong_colour", 0, 1, 1, 1, 2, 0, 1, 0);
    load_cell(3 * 8 + 3, 4);
    run_move("same_square", 0, 3, 3, 3, 3, 0, 1, 0);
    load_cell(5 * 8 + 0, 2); load_cell(5 * 8 + 2, 0);
    run_move("illegal", 0, 5, 0, 5, 2, 2, 0, 0);
    load_cell(6 * 8 + 0, 3); load_cell(6 * 8 + 2, 0);
    run_move("timeout", 0, 6, 0, 6, 2, -1, 1, 1);
    load_cell(7 * 8 + 7, 11); load_cell(7 * 8 + 4, 6);
    run_move("king_capture", 1, 7, 7, 7, 4, 0, 1, 0);

    // Reset while the destination write is being driven.
    load_cell(2 * 8 + 2, 3); load_cell(2 * 8 + 5, 0);
    v_delay = 0; v_verdict = 1'b1;
    issue(0, 2, 2, 2, 5);
    repeat (6) tick();
    check("rst_mid.wr_dst", 16'(bus.mem_write), 16'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.mem_write", 16'(bus.mem_write), 16'd0);
    check("rst_mid.busy", 16'(bus.busy), 16'd0);
    tick(); tick();
    check("rst_mid.move_done", 16'(bus.move_done), 16'd0);
    rst_n = 1'b1;
    tick();
    check_board("rst_mid.board");
    run_move("after_reset", 0, 2, 2, 2, 5, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      pl = $urandom_range(0, 1);
      ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) begin dx = ox; dy = oy; end
      else begin dx = $urandom_range(0, 7); dy = $urandom_range(0, 7); end
      r = $urandom_range(0, 9);
      if (r < 7) pc = (pl == 1 ? 7 : 1) + $urandom_range(0, 5);
      else if (r == 7) pc = 0;
      else pc = $urandom_range(1, 12);
      load_cell(ox * 8 + oy, pc);
      if (dx != ox || dy != oy)
        load_cell(dx * 8 + dy, $urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 12));
      run_move($sformatf("rand%0d", n), pl[0], ox, oy, dx, dy,
               $urandom_range(0, 6), $urandom_range(0, 3) != 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
